// File: rtl/peri_timer_pkg.sv
// peri_timer_pkg: shared types and default sizes for the multi-channel timer.
//   tmr_state_e : per-channel FSM state (IDLE, RUN, DONE)
//   tmr_mode_e  : load-time operating mode (ONE_SHOT, PERIODIC)
//   DEF_*       : default parameter values used by peri_timer_mc / peri_timer_ch
package peri_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tmr_state_e;

  typedef enum logic {
    ONE_SHOT = 1'b0,
    PERIODIC = 1'b1
  } tmr_mode_e;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_N_CH    = 4;
  localparam int DEF_PRESC_W = 8;

endpackage

// File: rtl/peri_timer_ch.sv
// peri_timer_ch: one down-counting timer channel.
//   clk_i      : clock, all state on rising edge
//   rst_ni     : asynchronous active-low reset
//   load_i     : load strobe, already qualified by the channel select
//   data_i     : start/reload value (0 forces DONE with an immediate irq)
//   mode_i     : 0 one-shot, 1 periodic (sampled with load_i)
//   presc_i    : tick every presc_i+1 cycles (sampled with load_i)
//   irq_ack_i  : clears the sticky irq flag
//   count_o    : current count
//   irq_o      : sticky terminal-count flag
//   running_o  : channel is in RUN
module peri_timer_ch
  import peri_timer_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic [WIDTH-1:0]   data_i,
  input  logic               mode_i,
  input  logic [PRESC_W-1:0] presc_i,
  input  logic               irq_ack_i,
  output logic [WIDTH-1:0]   count_o,
  output logic               irq_o,
  output logic               running_o
);

  tmr_state_e         state_reg;
  tmr_mode_e          mode_reg;
  logic [WIDTH-1:0]   count_reg;
  logic [WIDTH-1:0]   reload_reg;
  logic [PRESC_W-1:0] presc_reg;
  logic [PRESC_W-1:0] pcnt_reg;
  logic               irq_reg;

  logic tick;
  logic terminal;

  assign tick     = (state_reg == RUN) && (pcnt_reg == presc_reg);
  assign terminal = tick && (count_reg == WIDTH'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg  <= IDLE;
      mode_reg   <= ONE_SHOT;
      count_reg  <= '0;
      reload_reg <= '0;
      presc_reg  <= '0;
      pcnt_reg   <= '0;
      irq_reg    <= 1'b0;
    end else if (load_i) begin
      // A load overrides anything the counter would do this cycle,
      // including a coincident terminal event (its irq is dropped).
      count_reg  <= data_i;
      reload_reg <= data_i;
      mode_reg   <= tmr_mode_e'(mode_i);
      presc_reg  <= presc_i;
      pcnt_reg   <= '0;
      if (data_i == '0) begin
        state_reg <= DONE;
        irq_reg   <= 1'b1;
      end else begin
        state_reg <= RUN;
        if (irq_ack_i) irq_reg <= 1'b0;
      end
    end else begin
      // Set beats acknowledge when both land on the same edge.
      if (terminal)       irq_reg <= 1'b1;
      else if (irq_ack_i) irq_reg <= 1'b0;

      if (state_reg == RUN) begin
        if (tick) begin
          pcnt_reg <= '0;
          if (terminal) begin
            if (mode_reg == PERIODIC) begin
              count_reg <= reload_reg;
            end else begin
              count_reg <= '0;
              state_reg <= DONE;
            end
          end else begin
            count_reg <= count_reg - WIDTH'(1);
          end
        end else begin
          pcnt_reg <= pcnt_reg + PRESC_W'(1);
        end
      end
    end
  end

  assign count_o   = count_reg;
  assign irq_o     = irq_reg;
  assign running_o = (state_reg == RUN);

endmodule

// File: rtl/peri_timer_mc.sv
// peri_timer_mc: N_CH-channel down-counting timer peripheral.
//   clk_i      : clock
//   rst_ni     : asynchronous active-low reset
//   ch_sel_i   : channel addressed by load_i and shown on cuenta_o
//   data_i     : start/reload value
//   load_i     : one-cycle load strobe for the selected channel
//   mode_i     : 0 one-shot, 1 periodic
//   presc_i    : prescaler compare value (tick every presc_i+1 cycles)
//   irq_ack_i  : per-channel interrupt clear
//   cuenta_o   : count of the selected channel (0 if ch_sel_i >= N_CH)
//   irq_o      : sticky per-channel terminal-count flags
//   running_o  : per-channel RUN indication
// Optional build macro PERI_TIMER_SNAPSHOT_EN adds snap_i / snap_o: a
// coherent copy of all channel counts captured on snap_i.
module peri_timer_mc
  import peri_timer_pkg::*;
#(
  parameter  int WIDTH   = DEF_WIDTH,
  parameter  int N_CH    = DEF_N_CH,
  parameter  int PRESC_W = DEF_PRESC_W,
  localparam int SEL_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [SEL_W-1:0]   ch_sel_i,
  input  logic [WIDTH-1:0]   data_i,
  input  logic               load_i,
  input  logic               mode_i,
  input  logic [PRESC_W-1:0] presc_i,
  input  logic [N_CH-1:0]    irq_ack_i,
  output logic [WIDTH-1:0]   cuenta_o,
  output logic [N_CH-1:0]    irq_o,
`ifdef PERI_TIMER_SNAPSHOT_EN
  output logic [N_CH-1:0]    running_o,
  input  logic               snap_i,
  output logic [N_CH*WIDTH-1:0] snap_o
`else
  output logic [N_CH-1:0]    running_o
`endif
);

  logic [WIDTH-1:0] count_arr [N_CH];

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic load_ch;
    // Out-of-range selects match no channel, so such loads are dropped.
    assign load_ch = load_i && (ch_sel_i == SEL_W'(gi));

    peri_timer_ch #(
      .WIDTH   (WIDTH),
      .PRESC_W (PRESC_W)
    ) u_ch (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .load_i    (load_ch),
      .data_i    (data_i),
      .mode_i    (mode_i),
      .presc_i   (presc_i),
      .irq_ack_i (irq_ack_i[gi]),
      .count_o   (count_arr[gi]),
      .irq_o     (irq_o[gi]),
      .running_o (running_o[gi])
    );
  end

  always_comb begin
    cuenta_o = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_sel_i == SEL_W'(i)) cuenta_o = count_arr[i];
    end
  end

`ifdef PERI_TIMER_SNAPSHOT_EN
  logic [N_CH*WIDTH-1:0] snap_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      snap_reg <= '0;
    end else if (snap_i) begin
      for (int i = 0; i < N_CH; i++) snap_reg[i*WIDTH +: WIDTH] <= count_arr[i];
    end
  end

  assign snap_o = snap_reg;
`endif

endmodule

// File: tb/tb_peri_timer_mc.sv
// tb_peri_timer_mc: directed, table-driven bench for peri_timer_mc
// (default build, N_CH=4, WIDTH=32, PRESC_W=8).
module tb_peri_timer_mc;

  localparam int WIDTH   = 32;
  localparam int N_CH    = 4;
  localparam int PRESC_W = 8;
  localparam int SEL_W   = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [SEL_W-1:0]   ch_sel = '0;
  logic [WIDTH-1:0]   data = '0;
  logic               load = 1'b0;
  logic               mode = 1'b0;
  logic [PRESC_W-1:0] presc = '0;
  logic [N_CH-1:0]    ack = '0;
  logic [WIDTH-1:0]   cuenta;
  logic [N_CH-1:0]    irq;
  logic [N_CH-1:0]    running;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  peri_timer_mc #(
    .WIDTH   (WIDTH),
    .N_CH    (N_CH),
    .PRESC_W (PRESC_W)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .ch_sel_i  (ch_sel),
    .data_i    (data),
    .load_i    (load),
    .mode_i    (mode),
    .presc_i   (presc),
    .irq_ack_i (ack),
    .cuenta_o  (cuenta),
    .irq_o     (irq),
    .running_o (running)
  );

  typedef struct {
    logic               ld;
    logic [SEL_W-1:0]   sel;
    logic [WIDTH-1:0]   data;
    logic               md;
    logic [PRESC_W-1:0] pr;
    logic [N_CH-1:0]    ack;
    logic [WIDTH-1:0]   e_cnt;
    logic [N_CH-1:0]    e_irq;
    logic [N_CH-1:0]    e_run;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic ld, input logic [SEL_W-1:0] sel,
                              input logic [WIDTH-1:0] d, input logic md,
                              input logic [PRESC_W-1:0] pr, input logic [N_CH-1:0] ak,
                              input logic [WIDTH-1:0] ec, input logic [N_CH-1:0] ei,
                              input logic [N_CH-1:0] er);
    vec_t v;
    v.ld = ld; v.sel = sel; v.data = d; v.md = md; v.pr = pr; v.ack = ak;
    v.e_cnt = ec; v.e_irq = ei; v.e_run = er;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // One bus cycle: drive inputs, take one rising edge, settle, drop strobes.
  task automatic cyc(input logic ld, input logic [SEL_W-1:0] sel, input logic [WIDTH-1:0] d,
                     input logic md, input logic [PRESC_W-1:0] pr, input logic [N_CH-1:0] ak);
    load = ld; ch_sel = sel; data = d; mode = md; presc = pr; ack = ak;
    @(posedge clk);
    #1;
    load = 1'b0;
    ack  = '0;
  endtask

  initial begin
    // ---- vector table ----
    // one-shot ch1, load 5, presc 0
    add(1, 1, 5, 0, 0, 0,       5, 4'b0000, 4'b0010);
    add(0, 1, 0, 0, 0, 0,       4, 4'b0000, 4'b0010);
    add(0, 1, 0, 0, 0, 0,       3, 4'b0000, 4'b0010);
    add(0, 1, 0, 0, 0, 0,       2, 4'b0000, 4'b0010);
    add(0, 1, 0, 0, 0, 0,       1, 4'b0000, 4'b0010);
    add(0, 1, 0, 0, 0, 0,       0, 4'b0010, 4'b0000);
    add(0, 1, 0, 0, 0, 0,       0, 4'b0010, 4'b0000);
    add(0, 1, 0, 0, 0, 4'b0010, 0, 4'b0000, 4'b0000);
    // zero load ch0 in periodic mode -> DONE with irq
    add(1, 0, 0, 1, 0, 0,       0, 4'b0001, 4'b0000);
    add(0, 0, 0, 0, 0, 4'b0001, 0, 4'b0000, 4'b0000);
    // periodic ch2, load 3, presc 2: each value held 3 cycles, period 9
    add(1, 2, 3, 1, 2, 0,       3, 4'b0000, 4'b0100);
    add(0, 2, 0, 0, 0, 0,       3, 4'b0000, 4'b0100);
    add(0, 2, 0, 0, 0, 0,       3, 4'b0000, 4'b0100);
    add(0, 2, 0, 0, 0, 0,       2, 4'b0000, 4'b0100);
    add(0, 2, 0, 0, 0, 0,       2, 4'b0000, 4'b0100);
    add(0, 2, 0, 0, 0, 0,       2, 4'b0000, 4'b0100);
    add(0, 2, 0, 0, 0, 0,       1, 4'b0000, 4'b0100);
    add(0, 2, 0, 0, 0, 0,       1, 4'b0000, 4'b0100);
    add(0, 2, 0, 0, 0, 0,       1, 4'b0000, 4'b0100);
    add(0, 2, 0, 0, 0, 0,       3, 4'b0100, 4'b0100);
    add(0, 2, 0, 0, 0, 4'b0100, 3, 4'b0000, 4'b0100);
    add(0, 2, 0, 0, 0, 0,       3, 4'b0000, 4'b0100);
    add(0, 2, 0, 0, 0, 0,       2, 4'b0000, 4'b0100);
    add(0, 2, 0, 0, 0, 0,       2, 4'b0000, 4'b0100);
    add(0, 2, 0, 0, 0, 0,       2, 4'b0000, 4'b0100);
    add(0, 2, 0, 0, 0, 0,       1, 4'b0000, 4'b0100);
    add(0, 2, 0, 0, 0, 0,       1, 4'b0000, 4'b0100);
    add(0, 2, 0, 0, 0, 0,       1, 4'b0000, 4'b0100);
    add(0, 2, 0, 0, 0, 0,       3, 4'b0100, 4'b0100);
    add(1, 2, 0, 0, 0, 0,       0, 4'b0100, 4'b0000);
    add(0, 2, 0, 0, 0, 4'b0100, 0, 4'b0000, 4'b0000);

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    chk("reset_cuenta", cuenta, 0);
    chk("reset_irq", 32'(irq), 0);
    chk("reset_running", 32'(running), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- table ----
    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].ld, vecs[i].sel, vecs[i].data, vecs[i].md, vecs[i].pr, vecs[i].ack);
      $display("[TB] vec %0d ld=%0d sel=%0d data=0x%0h ack=%b -> cuenta=0x%0h irq=%b run=%b",
               i, vecs[i].ld, vecs[i].sel, vecs[i].data, vecs[i].ack, cuenta, irq, running);
      chk($sformatf("vec%0d_cuenta", i), cuenta, vecs[i].e_cnt);
      chk($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].e_irq));
      chk($sformatf("vec%0d_running", i), 32'(running), 32'(vecs[i].e_run));
    end

    // ---- collision: ack on the terminal edge, set wins ----
    cyc(1, 1, 3, 0, 0, 0);       chk("col1_load", cuenta, 3);
    cyc(0, 1, 0, 0, 0, 0);       chk("col1_c2", cuenta, 2);
    cyc(0, 1, 0, 0, 0, 0);       chk("col1_c1", cuenta, 1);
    cyc(0, 1, 0, 0, 0, 4'b0010);
    chk("col1_irq_set_wins", 32'(irq), 32'(4'b0010));
    chk("col1_cuenta", cuenta, 0);
    chk("col1_running", 32'(running), 0);
    $display("[TB] ack+terminal ch1 -> irq=%b", irq);

    // ---- collision: reload on the terminal edge, load wins ----
    cyc(0, 1, 0, 0, 0, 4'b0010); chk("col2_ack", 32'(irq), 0);
    cyc(1, 1, 2, 0, 0, 0);       chk("col2_load", cuenta, 2);
    cyc(0, 1, 0, 0, 0, 0);       chk("col2_c1", cuenta, 1);
    cyc(1, 1, 32'hFFFF, 0, 0, 0);
    chk("col2_cuenta", cuenta, 32'hFFFF);
    chk("col2_no_irq", 32'(irq), 0);
    chk("col2_running", 32'(running), 32'(4'b0010));
    $display("[TB] reload+terminal ch1 -> cuenta=0x%0h irq=%b", cuenta, irq);
    cyc(0, 1, 0, 0, 0, 0);       chk("col2_dec", cuenta, 32'hFFFE);
    cyc(1, 1, 0, 0, 0, 0);       chk("col2_stop_irq", 32'(irq), 32'(4'b0010));
    cyc(0, 1, 0, 0, 0, 4'b0010); chk("col2_stop_ack", 32'(irq), 0);

    // ---- independence: ch0 periodic 4, ch3 one-shot reloaded mid-run ----
    cyc(1, 0, 4, 1, 0, 0);       chk("ind_a0", cuenta, 4);
    cyc(1, 3, 10, 0, 0, 0);      chk("ind_a1_ch3", cuenta, 10);
    cyc(0, 0, 0, 0, 0, 0);       chk("ind_a2", cuenta, 2);
    cyc(1, 3, 7, 0, 0, 0);       chk("ind_a3_ch3", cuenta, 7);
    chk("ind_a3_irq", 32'(irq), 0);
    cyc(0, 0, 0, 0, 0, 0);       chk("ind_a4", cuenta, 4);
    chk("ind_a4_irq", 32'(irq), 32'(4'b0001));
    cyc(0, 0, 0, 0, 0, 4'b0001); chk("ind_a5", cuenta, 3);
    chk("ind_a5_irq", 32'(irq), 0);
    cyc(0, 0, 0, 0, 0, 0);       chk("ind_a6", cuenta, 2);
    cyc(0, 0, 0, 0, 0, 0);       chk("ind_a7", cuenta, 1);
    cyc(0, 0, 0, 0, 0, 0);       chk("ind_a8", cuenta, 4);
    chk("ind_a8_irq", 32'(irq), 32'(4'b0001));
    chk("ind_a8_running", 32'(running), 32'(4'b1001));
    $display("[TB] ch0 second period -> cuenta=0x%0h irq=%b run=%b", cuenta, irq, running);
    cyc(0, 3, 0, 0, 0, 0);       chk("ind_a9_ch3", cuenta, 1);
    cyc(0, 3, 0, 0, 0, 0);       chk("ind_a10_ch3", cuenta, 0);
    chk("ind_a10_irq", 32'(irq), 32'(4'b1001));
    chk("ind_a10_running", 32'(running), 32'(4'b0001));
    cyc(1, 0, 0, 0, 0, 0);       chk("ind_stop_run", 32'(running), 0);
    cyc(0, 0, 0, 0, 0, 4'b0001); chk("ind_stop_irq", 32'(irq), 32'(4'b1000));

    // ---- asynchronous reset mid-count ----
    cyc(1, 0, 100, 0, 0, 0);
    repeat (10) cyc(0, 0, 0, 0, 0, 0);
    chk("rst_pre_cuenta", cuenta, 90);
    chk("rst_pre_running", 32'(running), 32'(4'b0001));
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_async_cuenta", cuenta, 0);
    chk("rst_async_irq", 32'(irq), 0);
    chk("rst_async_running", 32'(running), 0);
    $display("[TB] async reset -> cuenta=0x%0h irq=%b run=%b", cuenta, irq, running);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    chk("rst_post_cuenta", cuenta, 0);
    chk("rst_post_running", 32'(running), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/peri_timer_mc.md
Name: peri_timer_mc

Overview:
Parametrised multi-channel down-counting timer peripheral; successor to the single-channel load-and-count-to-zero timer.
- Each of N_CH channels holds its own count, reload value, mode and prescaler.
- Supports one-shot and periodic (auto-reload) operation.
- Raises a sticky per-channel interrupt flag at terminal count.
- Sits on the peripheral bus side of the RISC-V SoC; the bus decoder drives channel select, load and acknowledge.

Parameters:
WIDTH, 32, count/data width in bits
N_CH, 4, number of independent channels (1..16)
PRESC_W, 8, prescaler compare width in bits
SEL_W, $clog2(N_CH) (min 1), channel select width (derived, localparam)

Ports:
clk_i  in  1  system clock, all state on rising edge
rst_ni  in  1  reset, asynchronous, active-low
ch_sel_i  in  SEL_W  channel addressed by load_i and observed on cuenta_o
data_i  in  WIDTH  start/reload value
load_i  in  1  one-cycle strobe: load selected channel
mode_i  in  1  sampled with load_i: 0 one-shot, 1 periodic
presc_i  in  PRESC_W  sampled with load_i: tick every presc_i+1 cycles
irq_ack_i  in  N_CH  per-channel interrupt clear
cuenta_o  out  WIDTH  current count of channel ch_sel_i (combinational mux of registers)
irq_o  out  N_CH  sticky terminal-count flags
running_o  out  N_CH  channel in RUN state

Behaviour:
- Reset (rst_ni low, asynchronous): all counts, reloads, prescalers and presc counters = 0; all channels IDLE; irq_o = 0; running_o = 0; cuenta_o = 0.
- Per-channel FSM states: IDLE, RUN, DONE.
  - IDLE/DONE -> RUN on load with data_i != 0.
  - Any state -> DONE on load with data_i == 0; irq set next edge, periodic mode ignored.
  - RUN -> DONE on terminal event in one-shot mode.
  - RUN stays RUN on terminal event in periodic mode.
- Load (load_i=1 at edge, channel ch_sel_i):
  - count <= data_i and reload <= data_i; mode and presc latched; presc counter <= 0.
  - cuenta_o shows data_i the cycle after the edge.
  - Load is accepted in any state, including mid-count (restart).
- Tick: in RUN, presc counter increments each cycle; when it equals the latched presc, tick fires and the counter returns to 0. presc=0 -> tick every cycle.
- On tick in RUN:
  - count > 1: count-1.
  - count == 1: terminal event, irq_o[ch] <= 1. One-shot: count <= 0, -> DONE. Periodic: count <= reload, stays RUN.
  - Period = reload x (presc+1) cycles; count never shows 0 in periodic mode.
- DONE holds count 0; only a new load leaves it.
- irq_o[ch] clears on irq_ack_i[ch]. Terminal event and ack in the same cycle: set wins.
- Load and terminal event on the same channel in the same cycle: load wins; that event's irq is not raised (existing irq unchanged).
- Loads to other channels never disturb a running channel.
- ch_sel_i >= N_CH: load ignored, cuenta_o = 0.
- Arithmetic is unsigned WIDTH-bit; no wrap below 0 is ever possible.

Optional Feature:
PERI_TIMER_SNAPSHOT_EN
- Defined: adds input snap_i (1) and output snap_o (N_CH*WIDTH). On snap_i, all channel counts are copied simultaneously into snapshot registers (reset 0), giving coherent multi-channel readout. snap_o is valid from the next cycle.
- Undefined: snap_i and snap_o are absent; no snapshot registers.

Decomposition:
- Package peri_timer_pkg holds:
  - typedef enum logic [1:0] tmr_state_e {IDLE, RUN, DONE}
  - typedef enum logic tmr_mode_e {ONE_SHOT, PERIODIC}
  - default width localparams
- Sub-module peri_timer_ch: one channel containing FSM, count, reload, prescaler and irq flag. It is instantiated N_CH times in a generate loop. Top level holds select decode, cuenta_o mux and the optional snapshot.

Test Plan:
- Reset mid-count: load ch0=100, presc=0, run 10 cycles, pulse rst_ni low asynchronously -> cuenta_o=0, irq_o=0, running_o=0 immediately, not at the next edge.
- One-shot: ch1 load 5, presc=0 -> count 5,4,3,2,1,0; irq_o[1]=1 exactly 5 cycles after load edge; running_o[1]=0; count stays 0.
- Periodic with prescaler: ch2 load 3, mode=1, presc=2 -> irq_o[2] sets every 9 cycles; after ack it re-sets at the next terminal event; sequence 3,2,1,3,... each value held 3 cycles.
- Zero load: ch0 load 0, mode=1 -> DONE, irq_o[0]=1 next cycle, running_o[0]=0.
- Collisions: ack irq_o[1] in the same cycle as its terminal event -> irq stays 1; reload ch1 with 0xFFFF on its terminal cycle -> count=0xFFFF, no new irq.
- Independence: ch0 periodic 4 and ch3 one-shot 10 running; reload ch3 mid-run -> ch0 period unchanged at 4 cycles.
